// File: rtl/uart_pkg.sv
// Shared definitions for the buffered MMIO UART.
//   - register addresses (DATA/STATUS/CTRL/LEVEL)
//   - STATUS and CTRL bit positions
//   - TX feeder state encoding
package uart_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;

  localparam int CT_RX_IE    = 0;
  localparam int CT_TXE_IE   = 1;
  localparam int CT_OVF_IE   = 2;
  localparam int CT_LOOPBACK = 3;
  localparam int CT_TX_FLUSH = 4;
  localparam int CT_RX_FLUSH = 5;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} feed_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head.
//   i_push/i_data : enqueue (ignored when full unless a pop happens the same cycle)
//   i_pop         : dequeue (ignored when empty)
//   i_flush       : empty the FIFO; wins over a same-cycle push/pop
//   o_head        : current head entry, valid when !o_empty
//   o_full/o_empty/o_count : occupancy
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == CW'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
  assign do_push = i_push & (~o_full | do_pop);
  assign o_head  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst | i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      o_count <= o_count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk)
    if (do_push & ~i_flush) mem[wr_ptr] <= i_data;
endmodule

// File: rtl/uart_rx.sv
// 8N1 deserializer with 2-flop input synchronizer and mid-bit sampling.
//   i_rx         : serial line
//   o_data       : received byte
//   o_data_valid : one-cycle pulse per frame with a good stop bit
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_valid
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [1:0]    sync;
  logic          rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st           <= RX_IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      sync         <= 2'b11;
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      sync         <= {sync[0], i_rx};
      o_data_valid <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) st <= RX_START;
        end
        // Re-check the start bit at its midpoint to reject glitches.
        RX_START:
          if (cnt == CW'(CPB / 2 - 1)) begin
            cnt <= '0;
            idx <= '0;
            st  <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        RX_DATA:
          if (cnt == CW'(CPB - 1)) begin
            cnt <= '0;
            sh  <= {rx_s, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) st <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        RX_STOP:
          if (cnt == CW'(CPB - 1)) begin
            st           <= RX_IDLE;
            o_data       <= sh;
            o_data_valid <= rx_s;
          end else cnt <= cnt + 1'b1;
        default: st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer.
//   i_tx_start/i_data : launch a frame when idle
//   o_tx              : serial line, idles high
//   o_busy            : high from the edge after start until the stop bit ends
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);

  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [9:0]    sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy <= 1'b0;
      o_tx   <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '1;
    end else if (!o_busy) begin
      if (i_tx_start) begin
        o_busy <= 1'b1;
        sh     <= {1'b1, i_data, 1'b0};
        o_tx   <= 1'b0;
        cnt    <= '0;
        idx    <= '0;
      end
    end else if (cnt == CW'(CPB - 1)) begin
      cnt <= '0;
      if (idx == 4'd9) begin
        o_busy <= 1'b0;
        o_tx   <= 1'b1;
      end else begin
        idx  <= idx + 1'b1;
        sh   <= {1'b1, sh[9:1]};
        o_tx <= sh[1];
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_fifo_mmio.sv
// Buffered, interrupt-capable UART on the MMIO bus.
//   i_sel/i_we/i_re/i_addr/i_wdata/o_rdata/o_rdy : zero-wait-state register port
//     0 DATA   : write pushes TX, read pops RX
//     1 STATUS : flags, W1C for TX_OVF/RX_OVF
//     2 CTRL   : RX_IE, TXE_IE, OVF_IE, LOOPBACK, self-clearing TX/RX flush
//     3 LEVEL  : {tx_count, rx_count}
//   i_rx_in / o_tx_out : serial lines
//   o_irq_req          : registered level interrupt
// Optional feature macro: UART_LOOPBACK_EN (CTRL.LOOPBACK routes TX into RX).
module uart_fifo_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [1:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdy,
  input  logic        i_rx_in,
  output logic        o_tx_out,
  output logic        o_irq_req
);
  logic wr, rd, wr_data, wr_status, wr_ctrl, rd_data;
  logic [3:0] ctrl;
  logic tx_ovf, rx_ovf, tx_ovf_set, rx_ovf_set;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_flush, rx_flush;
  logic [7:0] tx_head, rx_head, rx_byte, tx_data;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic rx_valid, tx_start, tx_busy, tx_ser, rx_line;
  logic tx_busy_st, irq_cond;
  feed_state_t fstate;
  logic unused_wdata;

  assign unused_wdata = ^i_wdata[15:6];

  assign o_rdy     = i_sel;
  assign wr        = i_sel & i_we;
  assign rd        = i_sel & i_re;
  assign wr_data   = wr & (i_addr == ADDR_DATA);
  assign wr_status = wr & (i_addr == ADDR_STATUS);
  assign wr_ctrl   = wr & (i_addr == ADDR_CTRL);
  assign rd_data   = rd & (i_addr == ADDR_DATA);
  assign tx_flush  = wr_ctrl & i_wdata[CT_TX_FLUSH];
  assign rx_flush  = wr_ctrl & i_wdata[CT_RX_FLUSH];

`ifdef UART_LOOPBACK_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
  assign rx_line  = ctrl[CT_LOOPBACK] ? tx_ser : i_rx_in;
  assign o_tx_out = ctrl[CT_LOOPBACK] ? 1'b1 : tx_ser;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h7;
  assign rx_line  = i_rx_in;
  assign o_tx_out = tx_ser;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(wr_data), .i_pop(tx_pop), .i_flush(tx_flush),
    .i_data(i_wdata[7:0]), .o_head(tx_head), .o_full(tx_full), .o_empty(tx_empty),
    .o_count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(rx_valid), .i_pop(rd_data), .i_flush(rx_flush),
    .i_data(rx_byte), .o_head(rx_head), .o_full(rx_full), .o_empty(rx_empty),
    .o_count(rx_count)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .i_clk(i_clk), .i_rst(i_rst), .i_tx_start(tx_start), .i_data(tx_data),
    .o_tx(tx_ser), .o_busy(tx_busy)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(rx_line), .o_data(rx_byte), .o_data_valid(rx_valid)
  );

  // Feeder pops the FIFO head in LAUNCH; a flush landing on the IDLE->LAUNCH
  // edge leaves LAUNCH with an empty FIFO, so it backs off without starting.
  assign tx_pop = (fstate == LAUNCH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fstate   <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (fstate)
        IDLE:      if (!tx_empty) fstate <= LAUNCH;
        LAUNCH: begin
          if (!tx_empty) begin
            tx_data  <= tx_head;
            tx_start <= 1'b1;
            fstate   <= WAIT_BUSY;
          end else fstate <= IDLE;
        end
        WAIT_BUSY: if (tx_busy)  fstate <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) fstate <= IDLE;
        default:   fstate <= IDLE;
      endcase
    end
  end

  // A same-cycle pop makes room, so only a true drop counts as overflow.
  assign tx_ovf_set = wr_data  & tx_full & ~tx_pop;
  assign rx_ovf_set = rx_valid & rx_full & ~rd_data;
  assign tx_busy_st = ~tx_empty | (fstate != IDLE);
  assign irq_cond   = (ctrl[CT_RX_IE]  & ~rx_empty)
                    | (ctrl[CT_TXE_IE] & tx_empty & (fstate == IDLE))
                    | (ctrl[CT_OVF_IE] & (tx_ovf | rx_ovf));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl      <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      o_irq_req <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= i_wdata[3:0] & CTRL_WMASK;
      // Set has priority over the W1C clear.
      tx_ovf    <= (tx_ovf & ~(wr_status & i_wdata[ST_TX_OVF])) | tx_ovf_set;
      rx_ovf    <= (rx_ovf & ~(wr_status & i_wdata[ST_RX_OVF])) | rx_ovf_set;
      o_irq_req <= irq_cond;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (rd) begin
      case (i_addr)
        ADDR_DATA:   if (!rx_empty) o_rdata = {8'h00, rx_head};
        ADDR_STATUS: begin
          o_rdata[ST_TX_BUSY]  = tx_busy_st;
          o_rdata[ST_RX_AVAIL] = ~rx_empty;
          o_rdata[ST_TX_FULL]  = tx_full;
          o_rdata[ST_RX_FULL]  = rx_full;
          o_rdata[ST_TX_OVF]   = tx_ovf;
          o_rdata[ST_RX_OVF]   = rx_ovf;
        end
        ADDR_CTRL:   o_rdata[3:0] = ctrl;
        default:     o_rdata = {8'(tx_count), 8'(rx_count)};
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio at 10 clocks per bit.
module tb_uart_fifo_mmio;
  import uart_pkg::*;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_sel = 1'b0, i_we = 1'b0, i_re = 1'b0, i_rx_in = 1'b1;
  logic [1:0]  i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_rdy, o_tx_out, o_irq_req;

  int tests = 0, fails = 0;

  always #5 i_clk = ~i_clk;

  uart_fifo_mmio #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_sel), .i_we(i_we), .i_re(i_re), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy), .i_rx_in(i_rx_in),
    .o_tx_out(o_tx_out), .o_irq_req(o_irq_req)
  );

  typedef struct {
    logic        sel, we, re;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

`ifdef UART_LOOPBACK_EN
  localparam logic [15:0] CTRL_RB = 16'h000F;
`else
  localparam logic [15:0] CTRL_RB = 16'h0007;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle; entered and left at posedge+1.
  task automatic bus(input logic sel, we, re, input logic [1:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic rdy);
    i_sel = sel; i_we = we; i_re = re; i_addr = addr; i_wdata = wd;
    @(negedge i_clk);
    rd = o_rdata; rdy = o_rdy;
    @(posedge i_clk); #1;
    i_sel = 1'b0; i_we = 1'b0; i_re = 1'b0; i_wdata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] x; logic r;
    bus(1'b1, 1'b1, 1'b0, a, d, x, r);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    logic r;
    bus(1'b1, 1'b0, 1'b1, a, 16'h0, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  // Drive one 8N1 frame plus one idle bit-time on i_rx_in.
  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      i_rx_in = f[k];
      repeat (10) @(posedge i_clk);
      #1;
    end
    i_rx_in = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(logic s, w, r, logic [1:0] a, logic [15:0] d, logic c, logic [15:0] e);
    vec_t v;
    v.sel = s; v.we = w; v.re = r; v.addr = a; v.wdata = d; v.chk = c; v.exp = e;
    return v;
  endfunction

  // Serial decoder for o_tx_out, sampling mid-bit on falling clock edges.
  logic [7:0] tx_q[$];
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge i_clk);
      if (o_tx_out === 1'b0) begin
        repeat (5) @(negedge i_clk);
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge i_clk);
          b[k] = o_tx_out;
        end
        repeat (10) @(negedge i_clk);
        tx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin : main
    vec_t v[16];
    logic [15:0] r;
    logic rdy;
    int avail_c, irq_c, lo_seen;

    v[0]  = mk(1, 0, 1, ADDR_STATUS, 16'h0000, 1, 16'h0000);
    v[1]  = mk(1, 0, 1, ADDR_LEVEL,  16'h0000, 1, 16'h0000);
    v[2]  = mk(1, 0, 1, ADDR_CTRL,   16'h0000, 1, 16'h0000);
    v[3]  = mk(1, 0, 1, ADDR_DATA,   16'h0000, 1, 16'h0000);
    v[4]  = mk(1, 1, 0, ADDR_CTRL,   16'h003F, 0, 16'h0000);
    v[5]  = mk(1, 0, 1, ADDR_CTRL,   16'h0000, 1, CTRL_RB);
    v[6]  = mk(1, 0, 0, ADDR_CTRL,   16'h0000, 1, 16'h0000);
    v[7]  = mk(0, 0, 1, ADDR_CTRL,   16'h0000, 1, 16'h0000);
    v[8]  = mk(1, 1, 0, ADDR_LEVEL,  16'hFFFF, 0, 16'h0000);
    v[9]  = mk(1, 0, 1, ADDR_LEVEL,  16'h0000, 1, 16'h0000);
    v[10] = mk(1, 1, 0, ADDR_STATUS, 16'hFFFF, 0, 16'h0000);
    v[11] = mk(1, 0, 1, ADDR_STATUS, 16'h0000, 1, 16'h0000);
    v[12] = mk(1, 1, 0, ADDR_CTRL,   16'h0004, 0, 16'h0000);
    v[13] = mk(1, 0, 1, ADDR_CTRL,   16'h0000, 1, 16'h0004);
    v[14] = mk(1, 1, 0, ADDR_CTRL,   16'h0000, 0, 16'h0000);
    v[15] = mk(1, 0, 1, ADDR_CTRL,   16'h0000, 1, 16'h0000);

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_tx_out", 16'(o_tx_out), 16'h0001);
    check("rst_irq", 16'(o_irq_req), 16'h0000);
    check("rst_rdata", o_rdata, 16'h0000);
    @(posedge i_clk); #1;

    // Register map vectors
    for (int i = 0; i < 16; i++) begin
      bus(v[i].sel, v[i].we, v[i].re, v[i].addr, v[i].wdata, r, rdy);
      check($sformatf("vec%0d_rdy", i), 16'(rdy), 16'(v[i].sel));
      if (v[i].chk) check($sformatf("vec%0d_rdata", i), r, v[i].exp);
    end

    // Three back-to-back TX bytes
    tx_q.delete();
    wr(ADDR_DATA, 16'h0041);
    wr(ADDR_DATA, 16'h0042);
    wr(ADDR_DATA, 16'h0043);
    for (int c = 0; c < 1000 && tx_q.size() < 3; c++) @(posedge i_clk);
    #1;
    check("tx_frames", 16'(tx_q.size()), 16'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("tx_byte%0d", k), (k < tx_q.size()) ? {8'h00, tx_q[k]} : 16'hFFFF, 16'(65 + k));
    repeat (10) @(posedge i_clk); #1;
    rd_chk("tx_done_status", ADDR_STATUS, 16'h0000);

    // RX fill to 16, overflow on 17th
    for (int b = 0; b < 16; b++) send_byte(8'(b));
    send_byte(8'hFF);
    rd_chk("rx_level_full", ADDR_LEVEL, 16'h0010);
    rd_chk("rx_status_ovf", ADDR_STATUS, 16'h002A);
    for (int k = 0; k < 16; k++) rd_chk($sformatf("rx_data%0d", k), ADDR_DATA, 16'(k));
    rd_chk("rx_empty_read", ADDR_DATA, 16'h0000);
    rd_chk("rx_level_empty", ADDR_LEVEL, 16'h0000);
    wr(ADDR_STATUS, 16'h0020);
    rd_chk("rx_ovf_clr", ADDR_STATUS, 16'h0000);

    // TX overflow while feeder sits in WAIT_DONE
    wr(ADDR_DATA, 16'h0011);
    repeat (8) @(posedge i_clk); #1;
    for (int k = 0; k < 17; k++) wr(ADDR_DATA, 16'(32 + k));
    rd_chk("tx_status_ovf", ADDR_STATUS, 16'h0015);
    rd_chk("tx_level_full", ADDR_LEVEL, 16'h1000);
    wr(ADDR_STATUS, 16'h0010);
    rd_chk("tx_ovf_clr", ADDR_STATUS, 16'h0005);
    wr(ADDR_CTRL, 16'h0010);
    rd_chk("tx_flush_level", ADDR_LEVEL, 16'h0000);
    rd_chk("tx_flush_ctrl", ADDR_CTRL, 16'h0000);
    repeat (150) @(posedge i_clk); #1;
    rd_chk("tx_flush_idle", ADDR_STATUS, 16'h0000);

    // RX interrupt timing
    wr(ADDR_CTRL, 16'h0001);
    @(negedge i_clk);
    check("irq_idle", 16'(o_irq_req), 16'h0000);
    @(posedge i_clk); #1;
    i_sel = 1'b1; i_re = 1'b1; i_addr = ADDR_STATUS;
    avail_c = -1; irq_c = -1;
    fork
      send_byte(8'h5A);
      for (int c = 0; c < 150; c++) begin
        @(negedge i_clk);
        if (avail_c < 0 && o_rdata[ST_RX_AVAIL]) avail_c = c;
        if (irq_c < 0 && o_irq_req) irq_c = c;
      end
    join
    @(posedge i_clk); #1;
    i_sel = 1'b0; i_re = 1'b0;
    check("irq_avail_seen", 16'(avail_c >= 0), 16'h0001);
    check("irq_rise_lag", 16'(irq_c - avail_c), 16'h0001);
    rd_chk("irq_data", ADDR_DATA, 16'h005A);
    i_sel = 1'b1; i_re = 1'b1; i_addr = ADDR_STATUS;
    @(negedge i_clk);
    check("irq_avail_fell", o_rdata, 16'h0000);
    check("irq_hold", 16'(o_irq_req), 16'h0001);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("irq_fall", 16'(o_irq_req), 16'h0000);
    @(posedge i_clk); #1;
    i_sel = 1'b0; i_re = 1'b0;
    wr(ADDR_CTRL, 16'h0000);

`ifdef UART_LOOPBACK_EN
    wr(ADDR_CTRL, 16'h0008);
    wr(ADDR_DATA, 16'h00A5);
    lo_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (o_tx_out !== 1'b1) lo_seen = 1;
    end
    @(posedge i_clk); #1;
    check("lb_tx_out_high", 16'(lo_seen), 16'h0000);
    rd_chk("lb_level", ADDR_LEVEL, 16'h0001);
    rd_chk("lb_data", ADDR_DATA, 16'h00A5);
    wr(ADDR_CTRL, 16'h0000);
`else
    lo_seen = 0;
`endif

    // Reset in the middle of a frame
    wr(ADDR_CTRL, 16'h0007);
    send_byte(8'h77);
    wr(ADDR_DATA, 16'h0031);
    wr(ADDR_DATA, 16'h0032);
    wr(ADDR_DATA, 16'h0033);
    wr(ADDR_DATA, 16'h0034);
    repeat (30) @(posedge i_clk); #1;
    @(negedge i_clk);
    check("pre_rst_irq", 16'(o_irq_req), 16'h0001);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("mid_rst_tx_out", 16'(o_tx_out), 16'h0001);
    check("mid_rst_irq", 16'(o_irq_req), 16'h0000);
    @(posedge i_clk); #1;
    rd_chk("mid_rst_level", ADDR_LEVEL, 16'h0000);
    rd_chk("mid_rst_ctrl", ADDR_CTRL, 16'h0000);
    rd_chk("mid_rst_status", ADDR_STATUS, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_fifo_mmio.md
# uart_fifo_mmio

Buffered, interrupt-capable UART peripheral on the processor's MMIO bus. It is the next generation of the single-byte UART MMIO block and keeps the same bus handshake and the same uart_tx/uart_rx serializers. It adds parametrised TX/RX FIFOs, sticky overflow flags, a control register with per-source interrupt enables and FIFO flush, and an optional internal loopback.

## Interface
- CLK_FREQ, 100_000_000, system clock in Hz; passed to uart_tx/uart_rx
- BAUD_RATE, 115200, line rate; passed to uart_tx/uart_rx
- TX_DEPTH, 16, TX FIFO entries; power of 2, range 2..128
- RX_DEPTH, 16, RX FIFO entries; power of 2, range 2..128
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_sel  in  1  peripheral select
- i_we  in  1  write enable
- i_re  in  1  read enable
- i_addr  in  2  register select
- i_wdata  in  16  write data
- o_rdata  out  16  read data; 0 unless i_sel and i_re are both high
- o_rdy  out  1  equals i_sel; zero-wait-state
- i_rx_in  in  1  serial receive line
- o_tx_out  out  1  serial transmit line; idles high
- o_irq_req  out  1  registered level interrupt request

## Operation
- **Address 0, DATA**
  - Write: pushes i_wdata[7:0] into the TX FIFO.
  - Write when TX is full: the byte is dropped and TX_OVF is set.
  - Read: returns {8'h00, RX head} and pops that entry.
  - Read when RX is empty: returns 16'h0000 and does not pop.
- **Address 1, STATUS**
  - Read bits:
    - bit0 TX_BUSY = TX FIFO non-empty or feeder not IDLE
    - bit1 RX_AVAIL
    - bit2 TX_FULL
    - bit3 RX_FULL
    - bit4 TX_OVF
    - bit5 RX_OVF
    - all other bits 0
  - Write: a 1 in bit4 or bit5 clears that flag (write-1-to-clear). Other bits are ignored.
- **Address 2, CTRL**
  - Read/write bits:
    - bit0 RX_IE
    - bit1 TXE_IE
    - bit2 OVF_IE
    - bit3 LOOPBACK
  - Self-clearing bits; they always read 0:
    - bit4 TX_FLUSH empties the TX FIFO. A byte already in the serializer still completes.
    - bit5 RX_FLUSH empties the RX FIFO.
- **Address 3, LEVEL**
  - Read: {tx_count[7:0], rx_count[7:0]}, counts zero-extended.
  - Write: ignored.
- **RX path**
  - A uart_rx o_data_valid pulse pushes the byte into the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and RX_OVF is set.
- **TX feeder FSM**
  - IDLE → LAUNCH when the TX FIFO is non-empty.
  - LAUNCH (exactly 1 cycle): pop the head into the tx data register, pulse i_tx_start, go to WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when tx_busy = 1.
  - WAIT_DONE → IDLE when tx_busy = 0.
- **Interrupt**: o_irq_req is the registered value of (RX_IE & RX_AVAIL) | (TXE_IE & TX FIFO empty & feeder IDLE) | (OVF_IE & (TX_OVF | RX_OVF)).
- **Simultaneous events**
  - Push and pop on a full FIFO: both take effect; no overflow.
  - Push and pop on an empty FIFO: the read returns 0 and the push succeeds.
  - A flush in the same cycle as a push to the same FIFO: the flush wins and the byte is discarded.
  - Overflow set and W1C clear in the same cycle: set wins.
- **Reset** (including mid-frame):
  - FIFOs empty, feeder IDLE, CTRL = 0, flags = 0.
  - o_irq_req = 0, o_tx_out = 1, o_rdata = 0.
  - A partially sent frame is abandoned.

## Timing
- Register reads are combinational in the same cycle as i_re.
- Pops, pushes and flag updates take effect at the next rising edge.
- A DATA write to an empty TX FIFO with the feeder IDLE:
  - feeder enters LAUNCH at edge +1;
  - start bit appears on o_tx_out per uart_tx latency after edge +2.
- Back-to-back frames are separated by the LAUNCH + WAIT_BUSY overhead, at least 2 cycles.
- o_irq_req lags its condition by exactly 1 cycle.
- RX_AVAIL rises 1 cycle after o_data_valid.

## Configuration
- UART_LOOPBACK_EN defined:
  - CTRL.LOOPBACK = 1 routes the uart_tx serial output into uart_rx.
  - o_tx_out is forced to 1 and i_rx_in is ignored.
- UART_LOOPBACK_EN undefined:
  - CTRL bit3 reads 0 and writes to it are ignored.
  - uart_rx is always driven by i_rx_in.

## Structure
- Package uart_pkg holds:
  - register address constants DATA/STATUS/CTRL/LEVEL;
  - STATUS and CTRL bit indices;
  - the feeder state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - show-ahead head, push/pop/flush, full/empty/count outputs;
  - instantiated once for TX and once for RX.
- uart_tx and uart_rx are reused unchanged.

## Test plan
Bench parameters: CLK_FREQ = 1_000_000, BAUD_RATE = 100_000 (10 clk/bit).
- Write 0x41, 0x42, 0x43 to DATA on back-to-back cycles → o_tx_out carries 0x41, 0x42, 0x43 in order; STATUS.TX_BUSY = 0 after the last stop bit.
- Drive 16 serial bytes 0x00..0x0F on i_rx_in, then a 17th byte 0xFF → LEVEL = 0x0010, RX_OVF = 1; 16 DATA reads return 0x0000..0x000F; a 17th read returns 0 with no pop.
- Write 17 bytes to DATA while the feeder is stalled in WAIT_DONE → TX_OVF = 1; writing 0x0010 to STATUS clears it.
- CTRL = 0x0001, one byte 0x5A received → o_irq_req rises 1 cycle after RX_AVAIL; reading DATA returns 0x005A and o_irq_req falls 1 cycle later.
- With UART_LOOPBACK_EN, CTRL = 0x0008, write 0xA5 → RX FIFO receives 0xA5 and o_tx_out stays 1 throughout.
- Assert i_rst mid-frame with 4 bytes queued → next cycle LEVEL = 0, o_tx_out = 1, o_irq_req = 0, CTRL reads 0.
